stream_compare_checker: RTL and testbench
=========================================

STREAM_COMPARE_CHECKER -- requirements
Module: stream_compare_checker

Interface
REQ-001 Parameter IMAGE_DEPTH, default 64: number of 128-bit blocks expected per frame.
REQ-002 Parameter ADDR_WIDTH, default 6: reference BRAM address width; IMAGE_DEPTH <= 2**ADDR_WIDTH.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start  in  1  single-cycle pulse; arms a compare pass.
REQ-007 s_axis_tdata  in  128  decrypted block from the AES output stream.
REQ-008 s_axis_tkeep  in  16  byte enables; bit k covers tdata[8k+7:8k].
REQ-009 s_axis_tlast  in  1  last block of frame.
REQ-010 s_axis_tvalid  in  1  upstream data valid.
REQ-011 s_axis_tready  out  1  checker accepts block.
REQ-012 ref_bram_addr  out  ADDR_WIDTH  reference (plaintext) BRAM read address.
REQ-013 ref_bram_en  out  1  reference BRAM read enable.
REQ-014 ref_bram_dout  in  128  reference data, valid one cycle after ref_bram_en.
REQ-015 done  out  1  pass complete; held high until next start or reset.
REQ-016 match_count  out  ADDR_WIDTH+1  blocks that matched.
REQ-017 mismatch_count  out  ADDR_WIDTH+1  blocks that mismatched.
REQ-018 first_mismatch_idx  out  ADDR_WIDTH  index of first mismatching block.
REQ-019 first_mismatch_valid  out  1  first_mismatch_idx holds a valid index.
REQ-020 early_last  out  1  tlast seen before block IMAGE_DEPTH-1.
REQ-021 missing_last  out  1  block IMAGE_DEPTH-1 accepted without tlast.

Function
REQ-022 FSM states IDLE, FETCH, WAIT, CMP, DONE; idx counter 0..IMAGE_DEPTH-1.
REQ-023 IDLE or DONE with start=1: clear counters, flags, idx=0, done=0, go FETCH.
REQ-024 start in FETCH, WAIT or CMP shall be ignored.
REQ-025 FETCH: ref_bram_en=1, ref_bram_addr=idx, go WAIT next cycle.
REQ-026 WAIT: register ref_bram_dout into ref_q, go CMP.
REQ-027 s_axis_tready=1 only in CMP; 0 in every other state, including reset.
REQ-028 CMP with tvalid=0: hold state, no counter change.
REQ-029 Block match: for every k with tkeep[k]=1, byte k of tdata equals byte k of ref_q; tkeep=0 bytes ignored; tkeep=16'h0000 counts as match.
REQ-030 Handshake in CMP: increment exactly one of match_count/mismatch_count in the same edge.
REQ-031 First mismatch of a pass latches first_mismatch_idx=idx and first_mismatch_valid=1; later mismatches leave it unchanged.
REQ-032 Handshake with tlast=1 and idx<IMAGE_DEPTH-1: set early_last, go DONE.
REQ-033 Handshake with idx=IMAGE_DEPTH-1 and tlast=0: set missing_last, go DONE.
REQ-034 Handshake with idx=IMAGE_DEPTH-1 and tlast=1: go DONE, no flag.
REQ-035 Otherwise handshake: idx=idx+1, go FETCH; sustained throughput one block per 3 cycles.
REQ-036 DONE: done=1, tready=0; outputs stable until start or rst.
REQ-037 match_count+mismatch_count equals accepted blocks; never wraps (max IMAGE_DEPTH).

Reset
REQ-038 rst=1 at any edge, including mid-pass: state=IDLE, idx=0, all outputs 0, ref_q=0.
REQ-039 Blocks presented during or before reset release shall not be accepted until start.

Structure
REQ-040 Shared package aes_stream_pkg holds DATA_W=128, KEEP_W=16 and the checker state enum.
REQ-041 One sub-module masked_block_cmp (combinational byte-masked 128-bit equality) instantiated once.

Verification
REQ-042 Reference = 0..63 counter pattern, stream identical, tlast on block 63 -> done, match_count=64, mismatch_count=0, no flags.
REQ-043 Block 5 byte 0 flipped, block 40 corrupted -> mismatch_count=2, match_count=62, first_mismatch_idx=5.
REQ-044 Block 7 byte 3 corrupted with tkeep=16'hFFF7 -> match_count=64.
REQ-045 tlast on block 9 -> early_last=1, done=1, match_count=10; block 63 without tlast -> missing_last=1.
REQ-046 tvalid toggled randomly at 50%, then rst asserted after block 20 and start reissued -> counters restart from 0, final match_count=64.

Source files
------------

// File: rtl/aes_stream_pkg.sv
// Shared widths and checker state encoding for the AES output-stream blocks.
package aes_stream_pkg;
  localparam int DATA_W = 128;
  localparam int KEEP_W = DATA_W / 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_WAIT  = 3'd2,
    ST_CMP   = 3'd3,
    ST_DONE  = 3'd4
  } chk_state_e;
endpackage

// File: rtl/stream_compare_checker_if.sv
// AXI-Stream style block bus carrying decrypted data into the checker.
interface stream_compare_checker_if import aes_stream_pkg::*; ();
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tlast;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/masked_block_cmp.sv
// Byte-masked equality of two 128-bit blocks; bytes with keep=0 always agree.
module masked_block_cmp import aes_stream_pkg::*; (
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  input  logic [KEEP_W-1:0] i_keep,
  output logic              o_match
);
  logic [KEEP_W-1:0] w_byte_ok;

  for (genvar k = 0; k < KEEP_W; k++) begin : g_byte
    assign w_byte_ok[k] = !i_keep[k] || (i_a[8*k +: 8] == i_b[8*k +: 8]);
  end

  assign o_match = &w_byte_ok;
endmodule

// File: rtl/stream_compare_checker.sv
// Compares a decrypted block stream against a plaintext reference BRAM,
// one block per FETCH/WAIT/CMP round, and reports match statistics per pass.
module stream_compare_checker import aes_stream_pkg::*; #(
  parameter int IMAGE_DEPTH = 64,
  parameter int ADDR_WIDTH  = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  stream_compare_checker_if.slave  s_axis,
  output logic [ADDR_WIDTH-1:0]    ref_bram_addr,
  output logic                     ref_bram_en,
  input  logic [DATA_W-1:0]        ref_bram_dout,
  output logic                     done,
  output logic [ADDR_WIDTH:0]      match_count,
  output logic [ADDR_WIDTH:0]      mismatch_count,
  output logic [ADDR_WIDTH-1:0]    first_mismatch_idx,
  output logic                     first_mismatch_valid,
  output logic                     early_last,
  output logic                     missing_last
);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMAGE_DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] IDX_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  chk_state_e            r_state;
  logic [ADDR_WIDTH-1:0] r_idx;
  logic [DATA_W-1:0]     r_ref_q;
  logic [ADDR_WIDTH:0]   r_match_cnt;
  logic [ADDR_WIDTH:0]   r_mism_cnt;
  logic [ADDR_WIDTH-1:0] r_first_idx;
  logic                  r_first_vld;
  logic                  r_early_last;
  logic                  r_missing_last;

  logic w_match;
  logic w_last_blk;

  masked_block_cmp u_cmp (
    .i_a     (s_axis.tdata),
    .i_b     (r_ref_q),
    .i_keep  (s_axis.tkeep),
    .o_match (w_match)
  );

  assign w_last_blk = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_idx          <= '0;
      r_ref_q        <= '0;
      r_match_cnt    <= '0;
      r_mism_cnt     <= '0;
      r_first_idx    <= '0;
      r_first_vld    <= 1'b0;
      r_early_last   <= 1'b0;
      r_missing_last <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_idx          <= '0;
            r_match_cnt    <= '0;
            r_mism_cnt     <= '0;
            r_first_idx    <= '0;
            r_first_vld    <= 1'b0;
            r_early_last   <= 1'b0;
            r_missing_last <= 1'b0;
            r_state        <= ST_FETCH;
          end
        end
        ST_FETCH: r_state <= ST_WAIT;
        ST_WAIT: begin
          r_ref_q <= ref_bram_dout;
          r_state <= ST_CMP;
        end
        ST_CMP: begin
          if (s_axis.tvalid) begin
            if (w_match) begin
              r_match_cnt <= r_match_cnt + CNT_ONE;
            end else begin
              r_mism_cnt <= r_mism_cnt + CNT_ONE;
              if (!r_first_vld) begin
                r_first_idx <= r_idx;
                r_first_vld <= 1'b1;
              end
            end
            // The final block index always ends the pass, tlast or not.
            if (w_last_blk) begin
              r_missing_last <= !s_axis.tlast;
              r_state        <= ST_DONE;
            end else if (s_axis.tlast) begin
              r_early_last <= 1'b1;
              r_state      <= ST_DONE;
            end else begin
              r_idx   <= r_idx + IDX_ONE;
              r_state <= ST_FETCH;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axis.tready        = (r_state == ST_CMP);
  assign ref_bram_en          = (r_state == ST_FETCH);
  assign ref_bram_addr        = r_idx;
  assign done                 = (r_state == ST_DONE);
  assign match_count          = r_match_cnt;
  assign mismatch_count       = r_mism_cnt;
  assign first_mismatch_idx   = r_first_idx;
  assign first_mismatch_valid = r_first_vld;
  assign early_last           = r_early_last;
  assign missing_last         = r_missing_last;
endmodule

// File: tb/tb_stream_compare_checker.sv
// Scoreboard bench: each pass pushes its expected summary; a monitor checks it on done.
module tb_stream_compare_checker;
  import aes_stream_pkg::*;
  localparam int DEPTH = 64;
  localparam int AW    = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, start;
  logic [AW-1:0]     ref_bram_addr;
  logic              ref_bram_en;
  logic [DATA_W-1:0] ref_bram_dout;
  logic              done;
  logic [AW:0]       match_count, mismatch_count;
  logic [AW-1:0]     first_mismatch_idx;
  logic              first_mismatch_valid, early_last, missing_last;

  stream_compare_checker_if s_axis();

  stream_compare_checker #(.IMAGE_DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .start                (start),
    .s_axis               (s_axis),
    .ref_bram_addr        (ref_bram_addr),
    .ref_bram_en          (ref_bram_en),
    .ref_bram_dout        (ref_bram_dout),
    .done                 (done),
    .match_count          (match_count),
    .mismatch_count       (mismatch_count),
    .first_mismatch_idx   (first_mismatch_idx),
    .first_mismatch_valid (first_mismatch_valid),
    .early_last           (early_last),
    .missing_last         (missing_last)
  );

  logic [DATA_W-1:0] ref_mem [DEPTH];
  always @(posedge clk) if (ref_bram_en) ref_bram_dout <= ref_mem[ref_bram_addr];

  typedef struct packed {
    logic [AW:0]   mc;
    logic [AW:0]   mm;
    logic [AW-1:0] fmi;
    logic          fmv;
    logic          early;
    logic          missing;
  } res_t;

  res_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out", name);
  endtask

  // Monitor: compare the pass summary on every rising edge of done.
  initial begin
    res_t e;
    logic pd = 1'b0;
    forever begin
      @(negedge clk);
      if (done === 1'b1 && pd !== 1'b1) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          chk("match_count",    match_count,          e.mc);
          chk("mismatch_count", mismatch_count,       e.mm);
          chk("first_mm_idx",   first_mismatch_idx,   e.fmi);
          chk("first_mm_valid", first_mismatch_valid, e.fmv);
          chk("early_last",     early_last,           e.early);
          chk("missing_last",   missing_last,         e.missing);
        end
      end
      pd = done;
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input logic [KEEP_W-1:0] k,
                      input logic l, input bit rnd);
    int t = 0;
    forever begin
      @(negedge clk);
      s_axis.tdata  = d;
      s_axis.tkeep  = k;
      s_axis.tlast  = l;
      s_axis.tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_axis.tvalid && s_axis.tready) begin
        @(posedge clk);
        #1 s_axis.tvalid = 1'b0;
        return;
      end
      if (++t > 200) begin
        fail_now("handshake");
        return;
      end
    end
  endtask

  // mode 0: clean, 1: corrupted blocks 5/40 plus an ignored start,
  // 2: masked corruption. rst_after >= 0 aborts the pass with a reset.
  task automatic run_pass(input int mode, input int nblk, input logic last_on,
                          input bit rnd, input res_t exp, input int rst_after);
    logic [DATA_W-1:0] d;
    logic [KEEP_W-1:0] k;
    int t;
    if (rst_after < 0) exp_q.push_back(exp);
    pulse_start();
    for (int b = 0; b < nblk; b++) begin
      d = ref_mem[b];
      k = '1;
      if (mode == 1 && b == 5)  d[7:0] = d[7:0] ^ 8'h01;
      if (mode == 1 && b == 40) d = ~d;
      if (mode == 2 && b == 7) begin d[31:24] = d[31:24] ^ 8'h5a; k = 16'hFFF7; end
      if (mode == 2 && b == 10) begin d = ~d; k = '0; end
      send(d, k, last_on && (b == nblk - 1), rnd);
      if (mode == 1 && b == 30) pulse_start();
      if (b == rst_after) begin
        @(negedge clk);
        rst = 1'b1;
        s_axis.tdata  = ref_mem[b + 1];
        s_axis.tkeep  = '1;
        s_axis.tlast  = 1'b0;
        s_axis.tvalid = 1'b1;
        @(negedge clk);
        chk("rst_tready", s_axis.tready, 1'b0);
        chk("rst_match",  match_count,   '0);
        chk("rst_done",   done,          1'b0);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_tready", s_axis.tready,  1'b0);
        chk("post_rst_mm",     mismatch_count, '0);
        s_axis.tvalid = 1'b0;
        return;
      end
    end
    t = 0;
    while (done !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    if (done !== 1'b1) fail_now("wait_done");
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = {4{32'(i)}};
    rst = 1'b1; start = 1'b0;
    s_axis.tdata = '0; s_axis.tkeep = '0; s_axis.tlast = 1'b0; s_axis.tvalid = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_tready", s_axis.tready, 1'b0);
    chk("reset_done",   done,          1'b0);
    chk("reset_en",     ref_bram_en,   1'b0);
    chk("reset_counts", {match_count, mismatch_count, first_mismatch_valid,
                         early_last, missing_last}, '0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_no_accept", s_axis.tready, 1'b0);
    s_axis.tvalid = 1'b0;

    run_pass(0, 64, 1'b1, 1'b0, '{mc: 7'd64, mm: 7'd0, fmi: 6'd0, fmv: 1'b0, early: 1'b0, missing: 1'b0}, -1);
    repeat (5) @(negedge clk);
    chk("done_held",  done,        1'b1);
    chk("count_held", match_count, 7'd64);

    run_pass(1, 64, 1'b1, 1'b0, '{mc: 7'd62, mm: 7'd2, fmi: 6'd5, fmv: 1'b1, early: 1'b0, missing: 1'b0}, -1);
    run_pass(2, 64, 1'b1, 1'b0, '{mc: 7'd64, mm: 7'd0, fmi: 6'd0, fmv: 1'b0, early: 1'b0, missing: 1'b0}, -1);
    run_pass(0, 10, 1'b1, 1'b0, '{mc: 7'd10, mm: 7'd0, fmi: 6'd0, fmv: 1'b0, early: 1'b1, missing: 1'b0}, -1);
    run_pass(0, 64, 1'b0, 1'b0, '{mc: 7'd64, mm: 7'd0, fmi: 6'd0, fmv: 1'b0, early: 1'b0, missing: 1'b1}, -1);
    run_pass(0, 64, 1'b1, 1'b1, '0, 20);
    run_pass(0, 64, 1'b1, 1'b1, '{mc: 7'd64, mm: 7'd0, fmi: 6'd0, fmv: 1'b0, early: 1'b0, missing: 1'b0}, -1);

    repeat (5) @(negedge clk);
    if (exp_q.size() != 0) fail_now("pending_results");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
